// File: rtl/huffman_gen.sv
// Symbol histogram over one gray_data frame followed by a sequential Huffman code build (one merge per clock).
// Define HUFFMAN_GEN_SAT_EN to make symbol counts saturate instead of wrapping.
module huffman_gen #(
   parameter int NSYM = 6,
   parameter int CW   = 8,
   parameter int HW   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 gray_valid,
   input  logic [7:0]           gray_data,
   output logic                 CNT_valid,
   output logic [NSYM*CW-1:0]   cnt_flat,
   output logic                 code_valid,
   output logic [NSYM*HW-1:0]   hc_flat,
   output logic [NSYM*HW-1:0]   m_flat,
   output logic [2:0]           state_o
);

   // gray_valid qualifies gray_data every cycle; there is no ready, samples outside IDLE/COUNT are dropped.
   localparam int WW = CW + 4;
   localparam int LW = $clog2(HW + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COUNT   = 3'd1,
      S_CNTOUT  = 3'd2,
      S_MERGE   = 3'd3,
      S_CODEOUT = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [NSYM-1:0][CW-1:0]   cnt_q,  cnt_d;
   logic [NSYM-1:0][WW-1:0]   w_q,    w_d;
   logic [NSYM-1:0][NSYM-1:0] mask_q, mask_d;
   logic [NSYM-1:0][HW-1:0]   hc_q,   hc_d;
   logic [NSYM-1:0][HW-1:0]   m_q,    m_d;
   logic [NSYM-1:0][LW-1:0]   len_q,  len_d;

   int              cnt_live, w_live;
   int              a_idx, b_idx;
   logic            a_found, b_found;
   logic [WW-1:0]   a_w, b_w;
   logic [NSYM-1:0] a_mask, b_mask;

   always_comb begin
      cnt_live = 0;
      w_live   = 0;
      for (int k = 0; k < NSYM; k++) begin
         if (cnt_q[k] != '0) cnt_live = cnt_live + 1;
         if (w_q[k] != '0)   w_live   = w_live + 1;
      end
   end

   // Two lightest live slots; strict '<' on an ascending scan gives ties to the lowest index.
   always_comb begin
      a_idx   = 0;
      a_found = 1'b0;
      a_w     = '0;
      a_mask  = '0;
      for (int j = 0; j < NSYM; j++) begin
         if (w_q[j] != '0 && (!a_found || w_q[j] < a_w)) begin
            a_found = 1'b1;
            a_idx   = j;
            a_w     = w_q[j];
            a_mask  = mask_q[j];
         end
      end
      b_idx   = 0;
      b_found = 1'b0;
      b_w     = '0;
      b_mask  = '0;
      for (int j = 0; j < NSYM; j++) begin
         if (j != a_idx && w_q[j] != '0 && (!b_found || w_q[j] < b_w)) begin
            b_found = 1'b1;
            b_idx   = j;
            b_w     = w_q[j];
            b_mask  = mask_q[j];
         end
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      w_d    = w_q;
      mask_d = mask_q;
      hc_d   = hc_q;
      m_d    = m_q;
      len_d  = len_q;
      case (state_q)
         S_IDLE: begin
            if (gray_valid) begin
               cnt_d = '0;
               hc_d  = '0;
               m_d   = '0;
               len_d = '0;
               for (int k = 0; k < NSYM; k++)
                  if (int'(gray_data) == k + 1) cnt_d[k] = CW'(1);
            end
         end
         S_COUNT: begin
            if (gray_valid) begin
               for (int k = 0; k < NSYM; k++) begin
                  if (int'(gray_data) == k + 1) begin
`ifdef HUFFMAN_GEN_SAT_EN
                     if (cnt_q[k] != {CW{1'b1}}) cnt_d[k] = cnt_q[k] + CW'(1);
`else
                     cnt_d[k] = cnt_q[k] + CW'(1);
`endif
                  end
               end
            end
         end
         S_CNTOUT: begin
            for (int k = 0; k < NSYM; k++) begin
               w_d[k]       = WW'(cnt_q[k]);
               mask_d[k]    = '0;
               mask_d[k][k] = 1'b1;
               if (cnt_live == 1 && cnt_q[k] != '0) m_d[k] = HW'(1);
            end
         end
         S_MERGE: begin
            if (a_found && b_found) begin
               // Symbols under a get a 1 at their next code bit, symbols under b a 0.
               for (int s = 0; s < NSYM; s++) begin
                  if (a_mask[s] || b_mask[s]) begin
                     for (int bi = 0; bi < HW; bi++)
                        if (len_q[s] == LW'(bi)) hc_d[s][bi] = a_mask[s];
                     len_d[s] = len_q[s] + LW'(1);
                     m_d[s]   = (m_q[s] << 1) | HW'(1);
                  end
               end
               for (int j = 0; j < NSYM; j++) begin
                  if (j == b_idx) begin
                     w_d[j]    = a_w + b_w;
                     mask_d[j] = a_mask | b_mask;
                  end
                  if (j == a_idx) begin
                     w_d[j]    = '0;
                     mask_d[j] = '0;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         w_q    <= '0;
         mask_q <= '0;
         hc_q   <= '0;
         m_q    <= '0;
         len_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         w_q    <= w_d;
         mask_q <= mask_d;
         hc_q   <= hc_d;
         m_q    <= m_d;
         len_q  <= len_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (gray_valid)  state_d = S_COUNT;
         S_COUNT:   if (!gray_valid) state_d = S_CNTOUT;
         S_CNTOUT:  state_d = (cnt_live <= 1) ? S_CODEOUT : S_MERGE;
         S_MERGE:   if (w_live <= 2) state_d = S_CODEOUT;
         S_CODEOUT: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      CNT_valid  = (state_q == S_CNTOUT);
      code_valid = (state_q == S_CODEOUT);
      state_o    = state_q;
   end

   assign cnt_flat = cnt_q;
   assign hc_flat  = hc_q;
   assign m_flat   = m_q;

endmodule

// File: tb/tb_huffman_gen.sv
// Bench for huffman_gen: directed frames with literal expectations plus random frames against a
// behavioural Huffman model; a second instance with CW=4 covers count overflow.
module tb_huffman_gen;

   localparam int NSYM = 6;
   localparam int CW   = 8;
   localparam int HW   = 8;
   localparam int CW4  = 4;

   typedef struct {
      int                 cnt_cyc;
      int                 code_cyc;
      logic [NSYM*CW-1:0] cnt;
      logic [NSYM*HW-1:0] hc;
      logic [NSYM*HW-1:0] m;
   } exp_t;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic               gray_valid, CNT_valid, code_valid;
   logic [7:0]         gray_data;
   logic [NSYM*CW-1:0] cnt_flat;
   logic [NSYM*HW-1:0] hc_flat, m_flat;
   logic [2:0]         state_dbg;

   logic                g4_valid, cv4, codev4;
   logic [7:0]          g4_data;
   logic [NSYM*CW4-1:0] cnt4;
   logic [NSYM*HW-1:0]  hc4, m4;
   logic [2:0]          state4_dbg;

   huffman_gen #(.NSYM(NSYM), .CW(CW), .HW(HW)) dut (
      .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
      .CNT_valid(CNT_valid), .cnt_flat(cnt_flat), .code_valid(code_valid),
      .hc_flat(hc_flat), .m_flat(m_flat), .state_o(state_dbg)
   );

   huffman_gen #(.NSYM(NSYM), .CW(CW4), .HW(HW)) dut4 (
      .clk(clk), .reset(reset), .gray_valid(g4_valid), .gray_data(g4_data),
      .CNT_valid(cv4), .cnt_flat(cnt4), .code_valid(codev4),
      .hc_flat(hc4), .m_flat(m4), .state_o(state4_dbg)
   );

   // scoreboard
   int n_checks = 0;
   int n_pass   = 0;
   exp_t exp_q[$];
   exp_t last_exp;
   logic [7:0] frm_q[$];
   logic               hold_valid = 1'b0;
   logic [NSYM*CW-1:0] hold_cnt = '0;
   logic [NSYM*HW-1:0] hold_hc = '0, hold_m = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: plain Huffman merge over count list, ties by (weight, slot index).
   function automatic void model(input int cnt[NSYM], output logic [NSYM*HW-1:0] hc_o,
                                 output logic [NSYM*HW-1:0] m_o, output int L);
      int w[NSYM];
      int mem[NSYM];
      int len[NSYM];
      int code[NSYM];
      int mk[NSYM];
      int a, b;
      L = 0;
      for (int k = 0; k < NSYM; k++) begin
         w[k] = cnt[k]; mem[k] = 1 << k; len[k] = 0; code[k] = 0; mk[k] = 0;
         if (cnt[k] != 0) L++;
      end
      if (L == 1)
         for (int k = 0; k < NSYM; k++) if (w[k] != 0) mk[k] = 1;
      for (int st = 0; st < L - 1; st++) begin
         a = -1;
         for (int j = 0; j < NSYM; j++) if (w[j] != 0 && (a < 0 || w[j] < w[a])) a = j;
         b = -1;
         for (int j = 0; j < NSYM; j++) if (j != a && w[j] != 0 && (b < 0 || w[j] < w[b])) b = j;
         for (int s = 0; s < NSYM; s++) begin
            if (((mem[a] >> s) & 1) == 1) begin
               code[s] = code[s] | (1 << len[s]);
               len[s]++; mk[s] = (mk[s] << 1) | 1;
            end else if (((mem[b] >> s) & 1) == 1) begin
               len[s]++; mk[s] = (mk[s] << 1) | 1;
            end
         end
         w[b] = w[b] + w[a]; mem[b] = mem[b] | mem[a]; w[a] = 0; mem[a] = 0;
      end
      for (int s = 0; s < NSYM; s++) begin
         hc_o[s*HW +: HW] = HW'(code[s]);
         m_o[s*HW +: HW]  = HW'(mk[s]);
      end
   endfunction

   // compare process: pulse schedule every cycle, values on pulses and while held
   exp_t ce;
   logic e_cv, e_cd;
   always @(negedge clk) begin
      e_cv = 1'b0;
      e_cd = 1'b0;
      if (exp_q.size() > 0) begin
         ce   = exp_q[0];
         e_cv = (cyc == ce.cnt_cyc);
         e_cd = (cyc == ce.code_cyc);
      end
      chk("cnt_valid", CNT_valid, e_cv);
      chk("code_valid", code_valid, e_cd);
      if (e_cv) chk("cnt_flat", cnt_flat, ce.cnt);
      if (e_cd) begin
         chk("hc_flat", hc_flat, ce.hc);
         chk("m_flat", m_flat, ce.m);
         chk("cnt_flat_at_code", cnt_flat, ce.cnt);
         void'(exp_q.pop_front());
         hold_cnt = ce.cnt; hold_hc = ce.hc; hold_m = ce.m; hold_valid = 1'b1;
      end else if (hold_valid) begin
         chk("hold_cnt", cnt_flat, hold_cnt);
         chk("hold_hc", hc_flat, hold_hc);
         chk("hold_m", m_flat, hold_m);
      end
   end

   // driver tasks
   task automatic wait_idle();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         chk("idle_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic send_frame(input bit junk);
      int   cnt[NSYM];
      exp_t e;
      int   n, L, c0, d;
      wait_idle();
      repeat ($urandom_range(0, 2) + 1) @(posedge clk);
      #1;
      hold_valid = 1'b0;
      c0 = cyc;
      n  = frm_q.size();
      for (int k = 0; k < NSYM; k++) cnt[k] = 0;
      for (int i = 0; i < n; i++) begin
         gray_valid = 1'b1;
         gray_data  = frm_q[i];
         d = int'(frm_q[i]);
         if (d >= 1 && d <= NSYM) begin
`ifdef HUFFMAN_GEN_SAT_EN
            if (cnt[d-1] < (1 << CW) - 1) cnt[d-1]++;
`else
            cnt[d-1] = (cnt[d-1] + 1) % (1 << CW);
`endif
         end
         @(posedge clk);
         #1;
      end
      gray_valid = 1'b0;
      gray_data  = 8'($urandom);
      model(cnt, e.hc, e.m, L);
      for (int k = 0; k < NSYM; k++) e.cnt[k*CW +: CW] = CW'(cnt[k]);
      e.cnt_cyc  = c0 + n + 1;
      e.code_cyc = e.cnt_cyc + ((L > 1) ? L - 1 : 0) + 1;
      exp_q.push_back(e);
      last_exp = e;
      if (junk) begin
         @(posedge clk);
         #1;
         while (cyc < e.code_cyc) begin
            gray_valid = 1'b1;
            gray_data  = 8'($urandom_range(0, 9));
            @(posedge clk);
            #1;
         end
         gray_valid = 1'b0;
      end
   endtask

   task automatic set_frame(input int len, input int s0, input int s1, input int s2,
                            input int s3, input int s4, input int s5);
      int v[6];
      v = '{s0, s1, s2, s3, s4, s5};
      frm_q.delete();
      for (int i = 0; i < len; i++) frm_q.push_back(8'(v[i]));
   endtask

   int t_mid, n_r, hi, r, c4;

   initial begin
      gray_valid = 1'b0; gray_data = '0; g4_valid = 1'b0; g4_data = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_cnt", cnt_flat, 0); chk("rst_hc", hc_flat, 0); chk("rst_m", m_flat, 0);
      chk("rst_cv", CNT_valid, 0); chk("rst_codev", code_valid, 0);
      reset = 1'b0;
      hold_valid = 1'b1;
      @(posedge clk);
      #1;

      set_frame(6, 1, 1, 1, 2, 2, 3);
      send_frame(1'b0);
      chk("t1_cnt", last_exp.cnt, 48'h000000010203);
      chk("t1_hc", last_exp.hc, 48'h000000010001);
      chk("t1_m", last_exp.m, 48'h000000030301);
      chk("t1_lat", 64'(last_exp.code_cyc - last_exp.cnt_cyc), 64'd3);

      set_frame(6, 1, 2, 3, 4, 5, 6);
      send_frame(1'b1);
      chk("t2_hc", last_exp.hc, 48'h020300010203);
      chk("t2_m", last_exp.m, 48'h030307070707);
      chk("t2_lat", 64'(last_exp.code_cyc - last_exp.cnt_cyc), 64'd6);

      set_frame(4, 0, 9, 0, 9, 0, 0);
      send_frame(1'b0);
      chk("t3_all", {last_exp.cnt, last_exp.hc, last_exp.m} == '0, 1'b1);
      chk("t3_lat", 64'(last_exp.code_cyc - last_exp.cnt_cyc), 64'd1);

      set_frame(3, 4, 4, 4, 0, 0, 0);
      send_frame(1'b0);
      chk("t4_cnt", last_exp.cnt, 48'h000003000000);
      chk("t4_m", last_exp.m, 48'h000001000000);
      chk("t4_lat", 64'(last_exp.code_cyc - last_exp.cnt_cyc), 64'd1);
      wait_idle();

      // CW=4 instance: symbol 2 twenty times
      @(posedge clk);
      #1;
      c4 = cyc;
      repeat (20) begin
         g4_valid = 1'b1; g4_data = 8'd2;
         @(posedge clk);
         #1;
      end
      g4_valid = 1'b0;
      while (cyc < c4 + 21) begin @(posedge clk); #1; end
      #3;
      chk("sat_cv", cv4, 1'b1);
`ifdef HUFFMAN_GEN_SAT_EN
      chk("sat_cnt", cnt4, 24'h0000F0);
`else
      chk("wrap_cnt", cnt4, 24'h000040);
`endif
      @(posedge clk);
      #4;
      chk("sat_codev", codev4, 1'b1);
      chk("sat_hc", hc4, 48'h0);
      chk("sat_m", m4, 48'h000000000100);

      // reset during the second merge cycle of the six-symbol frame
      set_frame(6, 1, 2, 3, 4, 5, 6);
      send_frame(1'b0);
      t_mid = last_exp.cnt_cyc + 2;
      while (cyc < t_mid) begin @(posedge clk); #1; end
      reset = 1'b1;
      exp_q.delete();
      hold_cnt = '0; hold_hc = '0; hold_m = '0; hold_valid = 1'b1;
      #1;
      chk("midrst_out", {cnt_flat, hc_flat, m_flat, CNT_valid, code_valid} == '0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      set_frame(2, 1, 2, 0, 0, 0, 0);
      send_frame(1'b0);
      chk("t6_hc", last_exp.hc, 48'h000000000001);
      chk("t6_m", last_exp.m, 48'h000000000101);

      // long frame to push a count past 2^CW
      frm_q.delete();
      for (int i = 0; i < 270; i++) frm_q.push_back(8'd3);
      for (int i = 0; i < 5; i++) frm_q.push_back(8'($urandom_range(1, NSYM)));
      send_frame(1'b0);

      // random frames
      for (int f = 0; f < 40; f++) begin
         frm_q.delete();
         n_r = $urandom_range(1, 30);
         hi  = $urandom_range(1, NSYM);
         for (int i = 0; i < n_r; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) frm_q.push_back(8'($urandom_range(0, 255)));
            else       frm_q.push_back(8'($urandom_range(1, hi)));
         end
         send_frame($urandom_range(0, 3) == 0);
      end
      wait_idle();
      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
